// File: rtl/motor_pkg.sv
// Shared types and constants for the stepper driver: FSM states, command
// type, direction encoding and the half-step coil table.
package motor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } motor_state_t;

  // Signed step displacement from the key-mapping stage.
  typedef logic signed [3:0] step_cmd_t;

  // Direction as stored in the driver; equals the sign bit of the command.
  localparam logic FWD = 1'b0;
  localparam logic REV = 1'b1;

  // Coil patterns {A,B,C,D} for half-step drive. Even entries alone give
  // the single-coil wave sequence.
  localparam logic [3:0] HALF_STEP_TAB [0:7] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  // Magnitude of a step command as 4-bit unsigned; -8 maps to 8.
  function automatic logic [3:0] cmd_mag(input step_cmd_t c);
    logic [3:0] u;
    u = c;
    return c[3] ? (~u + 4'd1) : u;
  endfunction

endpackage

// File: rtl/motor_phase_lut.sv
// Combinational coil-pattern lookup: phase index to {A,B,C,D}.
module motor_phase_lut
  import motor_pkg::*;
(
  input  logic [2:0] index,
  output logic [3:0] phase
);

  // Straight table read; no state here.
  always_comb begin
    phase = HALF_STEP_TAB[index];
  end

endmodule

// File: rtl/motor_step_driver.sv
// Stepper move sequencer: accepts a signed step count, then issues one coil
// phase advance every STEP_DIV cycles until the move is complete, tracking
// absolute position. Phase is held after a move to keep holding torque.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is combinational and high only in IDLE
// with stop low, so a new move can only be taken once the previous one has
// ended. Upstream must hold cmd stable until that transfer edge; cmd_valid
// while a move runs is ignored.
module motor_step_driver
  import motor_pkg::*;
#(
  parameter int STEP_DIV  = 250000,
  parameter bit HALF_STEP = 1'b1,
  parameter int POS_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              cmd,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    stop,
  output logic [3:0]              phase,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  localparam int             DIV_W      = $clog2(STEP_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(STEP_DIV - 1);
  // Wave mode skips the odd (two-coil) table entries.
  localparam logic [2:0]     IDX_INC    = HALF_STEP ? 3'd1 : 3'd2;

  motor_state_t             state_q, state_d;
  logic                     dir_q, dir_d;
  logic [3:0]               remaining_q, remaining_d;
  logic [DIV_W-1:0]         divider_q, divider_d;
  logic [2:0]               idx_q, idx_d;
  logic [3:0]               phase_q, phase_d;
  logic signed [POS_W-1:0]  pos_q, pos_d;
  logic                     done_q, done_d;

  logic                     accept;
  logic [2:0]               idx_step;
  logic [3:0]               lut_phase;

  assign cmd_ready = (state_q == IDLE) && !stop;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign phase     = phase_q;
  assign position  = pos_q;

  // Index the move would land on if a step is taken this cycle.
  assign idx_step = (dir_q == REV) ? (idx_q - IDX_INC) : (idx_q + IDX_INC);

  motor_phase_lut u_lut (
    .index (idx_step),
    .phase (lut_phase)
  );

  // State and datapath registers; everything clears on async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= FWD;
      remaining_q <= 4'd0;
      divider_q   <= '0;
      idx_q       <= 3'd0;
      phase_q     <= 4'b0000;
      pos_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      divider_q   <= divider_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      pos_q       <= pos_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: accept in IDLE, count down and step in RUN, abort on stop.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    divider_d   = divider_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    pos_d       = pos_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero command is consumed by the handshake but starts nothing.
        if (accept && (cmd != 4'd0)) begin
          dir_d       = cmd[3];
          remaining_d = cmd_mag(step_cmd_t'(cmd));
          divider_d   = DIV_RELOAD;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          // Abort wins over a pending step; phase/position/index stay put.
          state_d     = IDLE;
          remaining_d = 4'd0;
          divider_d   = '0;
        end else if (divider_q != '0) begin
          divider_d = divider_q - 1'b1;
        end else begin
          idx_d       = idx_step;
          phase_d     = lut_phase;
          pos_d       = (dir_q == REV) ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
          remaining_d = remaining_q - 4'd1;
          divider_d   = DIV_RELOAD;
          if (remaining_q == 4'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_motor_step_driver.sv
// Bench for motor_step_driver: two instances (half-step / STEP_DIV=4 and
// wave / STEP_DIV=2) driven one at a time; a step-event scoreboard is fed
// from a position/phase model and drained by a negedge monitor.
module tb_motor_step_driver;

  logic              clk;
  logic              rst_n;
  logic [3:0]        cmd_r   [2];
  logic [1:0]        valid_r;
  logic [1:0]        stop_r;
  logic [1:0]        ready_w;
  logic [3:0]        phase_w [2];
  logic [1:0]        busy_w;
  logic [1:0]        done_w;
  logic [15:0]       pos_w   [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Event record: {dut, edge number, phase, position, done}
  logic [53:0] exp_q[$];

  // Reference model state per instance
  int          m_idx   [2];
  logic [15:0] m_pos   [2];
  int          b_start [2];
  int          b_end   [2];
  logic [3:0]  prev_ph [2];
  logic [15:0] prev_pos[2];

  logic [3:0] ref_tab [8];

  motor_step_driver #(.STEP_DIV(4), .HALF_STEP(1'b1), .POS_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_r[0]), .cmd_valid(valid_r[0]),
    .cmd_ready(ready_w[0]), .stop(stop_r[0]), .phase(phase_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .position(pos_w[0])
  );

  motor_step_driver #(.STEP_DIV(2), .HALF_STEP(1'b0), .POS_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_r[1]), .cmd_valid(valid_r[1]),
    .cmd_ready(ready_w[1]), .stop(stop_r[1]), .phase(phase_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .position(pos_w[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic int div_of(input int s);
    return (s == 0) ? 4 : 2;
  endfunction

  function automatic int inc_of(input int s);
    return (s == 0) ? 1 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int s = 0; s < 2; s++) begin
      m_idx[s]    = 0;
      m_pos[s]    = 16'd0;
      b_start[s]  = 0;
      b_end[s]    = 0;
      prev_ph[s]  = 4'b0000;
      prev_pos[s] = 16'd0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a command, expect it to be taken on the next edge, and queue
  // every step event the move should produce (truncated by a planned stop).
  task automatic start_move(input int s, input logic [3:0] c, input int stop_at, output int a);
    int n, dir, e;
    @(negedge clk);
    cmd_r[s]   = c;
    valid_r[s] = 1'b1;
    check("ready_idle", 32'(ready_w[s]), 32'd1);
    a   = cyc + 1;
    n   = c[3] ? (16 - int'(c)) : int'(c);
    dir = c[3] ? -1 : 1;
    for (int k = 1; k <= n; k++) begin
      e = a + k * div_of(s);
      if (stop_at >= 0 && e >= a + stop_at) break;
      m_idx[s] = (m_idx[s] + dir * inc_of(s) + 8) % 8;
      m_pos[s] = m_pos[s] + 16'(dir);
      exp_q.push_back({1'(s), 32'(e), ref_tab[m_idx[s]], m_pos[s], (k == n)});
    end
    if (n > 0) begin
      b_start[s] = a;
      b_end[s]   = (stop_at >= 0) ? a + stop_at : a + n * div_of(s);
    end
    @(posedge clk);
    #1;
    valid_r[s] = 1'b0;
    cmd_r[s]   = 4'($urandom_range(0, 15));
  endtask

  // Ride out the move, poking cmd_valid with junk while it runs and
  // raising stop for one cycle where planned.
  task automatic finish_move(input int s, input int stop_at, input int a);
    int e_end;
    int guard;
    e_end = (b_start[s] == a) ? b_end[s] : a;
    guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        check("move_timeout", 32'(guard), 32'd0);
        valid_r[s] = 1'b0;
        stop_r[s]  = 1'b0;
        break;
      end
      if (cyc >= e_end) begin
        valid_r[s] = 1'b0;
        if (stop_at >= 0 && b_start[s] == a) begin
          check("ready_during_stop", 32'(ready_w[s]), 32'd0);
          stop_r[s] = 1'b0;
          #1;
          check("ready_after_stop", 32'(ready_w[s]), 32'd1);
        end
        break;
      end
      valid_r[s] = 1'($urandom_range(0, 1));
      cmd_r[s]   = 4'($urandom_range(0, 15));
      if (stop_at >= 0 && cyc == e_end - 1) stop_r[s] = 1'b1;
    end
  endtask

  task automatic run_move(input int s, input logic [3:0] c, input int stop_at);
    int a;
    start_move(s, c, stop_at, a);
    finish_move(s, stop_at, a);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Every cycle: busy against the model window; any phase/position change
  // or done pulse is an event that must match the head of the queue.
  always @(negedge clk) begin
    logic [53:0] got, want;
    logic        bexp;
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        bexp = (cyc >= b_start[s]) && (cyc < b_end[s]);
        n_tests++;
        if (busy_w[s] !== bexp) begin
          n_fail++;
          $display("FAIL busy[%0d]: got %0b, expected %0b (cycle %0d)", s, busy_w[s], bexp, cyc);
        end
        if (pos_w[s] !== prev_pos[s] || phase_w[s] !== prev_ph[s] || done_w[s] !== 1'b0) begin
          got = {1'(s), 32'(cyc), phase_w[s], pos_w[s], done_w[s]};
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event[%0d]: cycle %0d phase %b pos %0d done %0b, expected none",
                     s, cyc, phase_w[s], $signed(pos_w[s]), done_w[s]);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_fail++;
              $display("FAIL step_event: got dut%0d cyc %0d phase %b pos %0d done %0b, expected dut%0d cyc %0d phase %b pos %0d done %0b",
                       got[53], got[52:21], got[20:17], $signed(got[16:1]), got[0],
                       want[53], want[52:21], want[20:17], $signed(want[16:1]), want[0]);
            end
          end
        end
        prev_pos[s] = pos_w[s];
        prev_ph[s]  = phase_w[s];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int a, s, n, sa;
    logic [3:0] c;

    ref_tab = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    model_reset();
    rst_n   = 1'b0;
    valid_r = 2'b00;
    stop_r  = 2'b00;
    cmd_r[0] = 4'd0;
    cmd_r[1] = 4'd0;

    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_phase", 32'(phase_w[i]), 32'd0);
      check("reset_busy", 32'(busy_w[i]), 32'd0);
      check("reset_done", 32'(done_w[i]), 32'd0);
      check("reset_position", 32'(pos_w[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(ready_w[0]), 32'd1);

    // Directed moves
    run_move(0, 4'b0011, -1);          // +3 half-step
    run_move(0, 4'b1101, -1);          // -3 back to 0
    run_move(1, 4'b1000, -1);          // -8 wave
    run_move(0, 4'b0000, -1);          // zero command: nothing happens
    run_move(0, 4'b0111, 5);           // stop after the first step
    run_move(0, 4'b0010, -1);          // accepted normally afterwards
    run_move(0, 4'b0100, 8);           // stop coincides with a step edge
    run_move(1, 4'b0101, -1);

    // stop in IDLE blocks acceptance
    @(negedge clk);
    stop_r[1] = 1'b1;
    #1 check("ready_idle_stop", 32'(ready_w[1]), 32'd0);
    stop_r[1] = 1'b0;

    // Asynchronous reset in the middle of a move
    start_move(0, 4'b0101, -1, a);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midreset_phase", 32'(phase_w[i]), 32'd0);
      check("midreset_busy", 32'(busy_w[i]), 32'd0);
      check("midreset_done", 32'(done_w[i]), 32'd0);
      check("midreset_position", 32'(pos_w[i]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_after_midreset", 32'(ready_w[0]), 32'd1);

    // Randomised moves with occasional aborts
    for (int i = 0; i < 30; i++) begin
      s  = $urandom_range(0, 1);
      c  = 4'($urandom_range(0, 15));
      n  = c[3] ? (16 - int'(c)) : int'(c);
      sa = -1;
      if (n > 0 && $urandom_range(0, 3) == 0) sa = $urandom_range(1, n * div_of(s));
      run_move(s, c, sa);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
